// File: rtl/serial_subtractor.sv
// Bit-serial a-b (LSB first) through one full_subtractor cell; SERIAL_SUB_SIGNED_EN adds the overflow output.
// Latency: done pulses WIDTH+1 cycles after the accepted start edge; results hold until the next start.
// Backpressure: none; start is only sampled in IDLE and ignored while busy or done.

module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);
  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_SIGNED_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             borrow_reg;
  logic             cell_d, cell_bo;

  full_subtractor u_cell (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (borrow_reg),
    .Diff (cell_d),
    .Bout (cell_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (cnt == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      cnt        <= '0;
      borrow_reg <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr       <= a;
            b_sr       <= b;
            cnt        <= '0;
            borrow_reg <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            overflow   <= 1'b0;
`endif
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          diff       <= {cell_d, diff[WIDTH-1:1]};
          a_sr       <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr       <= {1'b0, b_sr[WIDTH-1:1]};
          borrow_reg <= cell_bo;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST) begin
            borrow_out <= cell_bo;
`ifdef SERIAL_SUB_SIGNED_EN
            overflow   <= borrow_reg ^ cell_bo;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with a cycle-level arithmetic reference model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_SIGNED_EN
  logic         overflow;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic sovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sd;
    sd = int'($signed(x)) - int'($signed(y));
    return (sd < -(2 ** (W - 1))) || (sd > (2 ** (W - 1)) - 1);
  endfunction

  // Reference model: phase 0 idle, 1..W busy, W+1 result cycle.
  int           m_phase = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_diff = '0;
  logic         m_bo = 1'b0, m_ov = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_diff  <= '0;
      m_bo    <= 1'b0;
      m_ov    <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_a     <= a;
        m_b     <= b;
        m_diff  <= '0;
        m_bo    <= 1'b0;
        m_ov    <= 1'b0;
      end
    end else if (m_phase == W) begin
      m_phase <= W + 1;
      m_diff  <= m_a - m_b;
      m_bo    <= (m_a < m_b);
      m_ov    <= sovf(m_a, m_b);
    end else if (m_phase == W + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= W));
    chk("done", 32'(done), 32'(m_phase == W + 1));
    chk("borrow_out", 32'(borrow_out), 32'(m_bo));
    if (m_phase == 0 || m_phase == W + 1)
      chk("diff", 32'(diff), 32'(m_diff));
`ifdef SERIAL_SUB_SIGNED_EN
    chk("overflow", 32'(overflow), 32'(m_ov));
`endif
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] ed,
                        input logic eb, input logic eo, input bit glitch);
    int n, nb;
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (glitch && n == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      if (glitch && n == 4) start = 1'b0;
      if (busy) nb++;
    end while (!done && n < 30);
    chk("done_latency", n, W + 1);
    chk("busy_cycles", nb, W);
    chk("diff_lit", 32'(diff), 32'(ed));
    chk("model_diff", 32'(m_diff), 32'(ed));
    chk("borrow_lit", 32'(borrow_out), 32'(eb));
    chk("model_borrow", 32'(m_bo), 32'(eb));
    chk("model_ovf", 32'(m_ov), 32'(eo));
`ifdef SERIAL_SUB_SIGNED_EN
    chk("ovf_lit", 32'(overflow), 32'(eo));
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    chk("wait_done_timeout", 32'(n < 30), 1);
    t = cyc;
  endtask

  initial begin
    int nd, t1, t2;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_borrow", 32'(borrow_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);

    // Async reset between edges must clear held results at once.
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_diff", 32'(diff), 0);
    chk("arst_borrow", 32'(borrow_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    #2 rst = 1'b0;

    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);

    // Abort mid-operation.
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);

    run_op(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1, 1'b0);

    // start held high: second op begins as soon as IDLE is re-entered.
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    wait_done(t1);
    chk("b2b_diff1", 32'(diff), 32'h0F0);
    @(negedge clk);
    wait_done(t2);
    start = 1'b0;
    chk("b2b_spacing", t2 - t1, W + 2);
    chk("b2b_diff2", 32'(diff), 32'h0F0);
    chk("b2b_borrow2", 32'(borrow_out), 1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing `a - b - 0` one bit per clock, LSB first, through a single `full_subtractor` cell with a registered borrow fed back into `Bin`. It sits directly upstream of the `full_subtractor` cell, sequencing its operand bits and consuming its `Diff`/`Bout` outputs each cycle. It provides an area-minimal subtract path for multi-bit datapaths where latency is acceptable.

## Interface
- `WIDTH`, default 8: operand and result width, ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on the accepted start edge.
- `b`  in  WIDTH  subtrahend; captured on the accepted start edge.
- `busy`  out  1  high while bits are being processed (RUN).
- `done`  out  1  one-cycle pulse when the result is valid.
- `diff`  out  WIDTH  result `a - b` mod 2^WIDTH.
- `borrow_out`  out  1  final borrow; high iff `a < b` unsigned.
- `overflow`  out  1  present only with `SERIAL_SUB_SIGNED_EN`; signed overflow.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE when the bit counter reaches WIDTH-1.
  - DONE → IDLE unconditionally.
- On start acceptance:
  - load `a` and `b` into shift registers;
  - clear the borrow register and the bit counter;
  - clear `diff`, `borrow_out` and `overflow`.
- Each RUN cycle:
  - the cell computes with inputs A=a_sr[0], B=b_sr[0], Bin=borrow_reg;
  - `Diff` shifts into `diff` at bit WIDTH-1, and the old contents shift right;
  - a_sr and b_sr shift right;
  - borrow_reg ← `Bout`;
  - the counter increments.
- On the last RUN cycle (counter = WIDTH-1), `borrow_out` ← `Bout`.
- `start` is ignored in RUN and DONE. The operand inputs are don't-care except on the accepting edge.
- `diff`, `borrow_out` and `overflow` hold their values from DONE until the next accepted start.
- Arithmetic is unsigned modulo 2^WIDTH. There is no external borrow-in: the first Bin is always 0.

## Timing
- Reset (async assert, held while `rst`=1):
  - state = IDLE;
  - `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `overflow`=0;
  - shift registers, counter and borrow_reg = 0.
- Reset asserted mid-RUN aborts the operation. No `done` is produced.
- With `start` sampled high at edge N:
  - `busy`=1 for cycles N+1 … N+WIDTH (exactly WIDTH cycles);
  - `done`=1 for cycle N+WIDTH+1 only, with `busy`=0.
- Results are stable and valid in the same cycle `done` is high.
- Minimum start-to-start spacing is WIDTH+2 edges. A `start` held high through DONE is accepted at the first edge after returning to IDLE.
- `busy` and `done` are registered state decodes, with no combinational path from `start`.

## Configuration
- Macro: `SERIAL_SUB_SIGNED_EN`.
- Defined:
  - adds the `overflow` port;
  - on the last RUN cycle, `overflow` ← borrow_reg XOR `Bout` (borrow into the MSB XOR borrow out of the MSB);
  - `overflow` is held with the other results and cleared on reset or start.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert `rst` asynchronously → all outputs 0 immediately, state IDLE.
- Basic subtract: start with a=0x05, b=0x03 → `done` 9 edges after start; diff=0x02, borrow_out=0.
  - Cycle check: `busy` high exactly 8 cycles, `done` high exactly 1 cycle.
- Underflow and zero:
  - a=0x03, b=0x05 → diff=0xFE, borrow_out=1.
  - a=0x00, b=0x00 → diff=0x00, borrow_out=0.
- Signed overflow (macro defined): a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1.
  - Also check a=0x05, b=0x03 → overflow=0.
- Start while busy: pulse `start` with a=0xFF, b=0x00 at cycle 3 of RUN for 0x05-0x03 → ignored; result still 0x02.
- Reset mid-op: assert `rst` at RUN cycle 4 → no `done` pulse.
  - Then start a=0xAA, b=0x55 → diff=0x55, borrow_out=0.
  - Then a back-to-back start held high through DONE → next op accepted in IDLE; `done` spacing is 10 edges.
